iq_capture: RTL and testbench

- Downstream consumer of a GPS/E1B demodulator channel's serial IQ accumulator output.
- On each code epoch it generates the `shift` strobe stream and samples the channel's serial output bit-by-bit.
- Bits are packed MSB-first into 16-bit words and buffered in a small FIFO that the embedded CPU drains by register read.
- Frees the CPU from bit-banging the accumulator dump and flags lost epochs.

---
 rtl/iq_capture_pkg.sv | 32 +++
 rtl/iq_fifo.sv | 91 +++++++++
 rtl/iq_capture.sv | 139 +++++++++++++
 tb/tb_iq_capture.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_capture_pkg.sv
// Shared definitions for the IQ accumulator capture path: word width,
// capture FSM state encoding and constant helper functions.
package iq_capture_pkg;

   localparam int IQ_WORD_W = 16;

   // Accumulator geometry of the existing demodulator channels.
   localparam int GPS_INTEG_BITS = 20;
   localparam int GPS_NREG       = 6;
   localparam int E1B_NREG       = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_FLUSH = 2'd3
   } cap_state_e;

   // Integer ceiling division, used for words per dump.
   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Bits needed to index v entries (ceil(log2(v))).
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/iq_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head output,
// full/empty/count status and a synchronous clear. Async active-low reset.
module iq_fifo
   import iq_capture_pkg::*;
#(
   parameter int W     = IQ_WORD_W,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   wr,
   input  logic [W-1:0]           wdata,
   input  logic                   rd,
   output logic [W-1:0]           rdata,
   output logic                   full,
   output logic                   empty,
   output logic [clog2(DEPTH):0]  count
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [W-1:0]  rdata_q, rdata_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic          do_pop, do_push, mem_we;
   logic [CW-1:0] remaining;

   // Pointer, occupancy and registered-head next-state logic.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      rdata_d   = rdata_q;
      mem_we    = 1'b0;
      do_pop    = rd && (count_q != '0);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      do_push   = wr && ((count_q != FULL_CNT) || do_pop);
      remaining = count_q - CW'(do_pop);
      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         rdata_d = '0;
      end else begin
         mem_we  = do_push;
         rptr_d  = rptr_q + AW'(do_pop);
         wptr_d  = wptr_q + AW'(do_push);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
         if (remaining == '0) begin
            // Nothing left behind the head: the incoming word becomes the head.
            if (do_push) rdata_d = wdata;
         end else begin
            rdata_d = mem_q[rptr_d];
         end
      end
   end

   // Control and head registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         rdata_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage array write port.
   // NOTE: the storage array has no reset; occupancy is tracked by count_q, so contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wptr_q] <= wdata;
   end

   assign rdata = rdata_q;
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);

endmodule

// File: rtl/iq_capture.sv
// Epoch-triggered capture of the demodulator's serial IQ accumulator dump.
// Generates the shift strobe, packs sin MSB-first into 16-bit words and
// buffers them in an FWFT FIFO drained by the CPU. Flags lost epochs and
// dropped words in a sticky overrun bit.
module iq_capture
   import iq_capture_pkg::*;
#(
   parameter int INTEG_BITS = GPS_INTEG_BITS,
   parameter int NREG       = GPS_NREG,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        epoch,
   input  logic                        sin,
   output logic                        shift,
   input  logic                        rd,
   output logic [IQ_WORD_W-1:0]        rdata,
   output logic                        empty,
   output logic [clog2(FIFO_DEPTH):0]  count,
   output logic                        overrun,
   input  logic                        clr
);

   localparam int NBITS    = NREG * INTEG_BITS;
   localparam int NWORDS   = ceil_div(NBITS, IQ_WORD_W);
   localparam int REM      = NBITS % IQ_WORD_W;
   localparam int FLUSH_SH = IQ_WORD_W - REM;
   localparam int WCNT_W   = clog2(NWORDS + 1);

   // Final bit of a dump: bit LAST_B of word LAST_W.
   localparam logic [WCNT_W-1:0] LAST_W = WCNT_W'(NWORDS - 1);
   localparam logic [3:0]        LAST_B = (REM == 0) ? 4'd15 : 4'(REM - 1);

   cap_state_e           state_q, state_d;
   logic [3:0]           bcnt_q, bcnt_d;   // bit within word; also the WAIT timer
   logic [WCNT_W-1:0]    wcnt_q, wcnt_d;   // words pushed this dump
   logic [IQ_WORD_W-1:0] pack_q, pack_d;
   logic                 overrun_q, overrun_d;
   logic                 push, drop, fifo_full, last_bit;
   logic [IQ_WORD_W-1:0] push_word, shifted;

   assign shifted  = {pack_q[IQ_WORD_W-2:0], sin};
   assign last_bit = (wcnt_q == LAST_W) && (bcnt_q == LAST_B);

   // Capture FSM: next state, counters, packing register and push request.
   always_comb begin
      state_d   = state_q;
      bcnt_d    = bcnt_q;
      wcnt_d    = wcnt_q;
      pack_d    = pack_q;
      shift     = 1'b0;
      push      = 1'b0;
      push_word = '0;
      case (state_q)
         ST_IDLE: begin
            if (epoch) begin
               state_d = ST_WAIT;
               bcnt_d  = '0;
               wcnt_d  = '0;
            end
         end
         ST_WAIT: begin
            // Two cycles: the demodulator loads its serial register two edges after ms0.
            if (bcnt_q == 4'd1) begin
               state_d = ST_SHIFT;
               bcnt_d  = '0;
            end else begin
               bcnt_d = bcnt_q + 4'd1;
            end
         end
         ST_SHIFT: begin
            shift  = 1'b1;
            pack_d = shifted;
            bcnt_d = bcnt_q + 4'd1;
            if (bcnt_q == 4'd15) begin
               push      = 1'b1;
               push_word = shifted;
               wcnt_d    = wcnt_q + WCNT_W'(1);
            end
            if (last_bit) state_d = (REM != 0) ? ST_FLUSH : ST_IDLE;
         end
         ST_FLUSH: begin
            // Partial word sits in the LSBs; left-justify it with zero padding.
            push      = 1'b1;
            push_word = pack_q << FLUSH_SH;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sticky overrun: lost epoch or dropped word; clr wins over a same-cycle set.
   always_comb begin
      drop      = push && fifo_full && !rd;
      overrun_d = overrun_q;
      if (clr) begin
         overrun_d = 1'b0;
      end else if ((epoch && (state_q != ST_IDLE)) || drop) begin
         overrun_d = 1'b1;
      end
   end

   // FSM, counter, packing and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bcnt_q    <= '0;
         wcnt_q    <= '0;
         pack_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bcnt_q    <= bcnt_d;
         wcnt_q    <= wcnt_d;
         pack_q    <= pack_d;
         overrun_q <= overrun_d;
      end
   end

   assign overrun = overrun_q;

   iq_fifo #(
      .W     (IQ_WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .wr    (push),
      .wdata (push_word),
      .rd    (rd),
      .rdata (rdata),
      .full  (fifo_full),
      .empty (empty),
      .count (count)
   );

endmodule

// File: tb/tb_iq_capture.sv
// Self-checking bench for iq_capture. Instance A: 18x6 bits (108, with a
// flush word) and an 8-deep FIFO; instance B: 16x12 bits (192, no flush).
// Expected words come from the bit arrays fed to sin, packed by plain
// arithmetic, or from a hand-written pattern table.
module tb_iq_capture;

   logic        clk;
   logic        rst_n;
   logic        epoch_a, sin_a, shift_a, rd_a, empty_a, overrun_a, clr_a;
   logic [15:0] rdata_a;
   logic [3:0]  count_a;
   logic        epoch_b, sin_b, shift_b, rd_b, empty_b, overrun_b, clr_b;
   logic [15:0] rdata_b;
   logic [4:0]  count_b;

   iq_capture #(.INTEG_BITS(18), .NREG(6), .FIFO_DEPTH(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .epoch(epoch_a), .sin(sin_a), .shift(shift_a),
      .rd(rd_a), .rdata(rdata_a), .empty(empty_a), .count(count_a),
      .overrun(overrun_a), .clr(clr_a)
   );

   iq_capture #(.INTEG_BITS(16), .NREG(12), .FIFO_DEPTH(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .epoch(epoch_b), .sin(sin_b), .shift(shift_b),
      .rd(rd_b), .rdata(rdata_b), .empty(empty_b), .count(count_b),
      .overrun(overrun_b), .clr(clr_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [15:0] pat;
      logic [15:0] exp_full;
      logic [15:0] exp_last;
   } vec_t;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic        bits_a [256];
   logic        bits_b [256];
   int          idx_a, idx_b, shift_cnt_a;
   bit          rand_rd;
   logic [15:0] got_a[$], exp_a[$], got_b[$], exp_b[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // One clock: record popped head words, advance to the next falling edge,
   // then play the demodulator role (present the next dump bit when shift is high).
   task automatic cyc();
      if (rd_a && !empty_a) got_a.push_back(rdata_a);
      if (rd_b && !empty_b) got_b.push_back(rdata_b);
      @(posedge clk);
      @(negedge clk);
      if (shift_a) begin
         if (idx_a < 256) sin_a = bits_a[idx_a];
         idx_a++;
         shift_cnt_a++;
      end
      if (shift_b) begin
         if (idx_b < 256) sin_b = bits_b[idx_b];
         idx_b++;
      end
      if (rand_rd) rd_a = 1'($urandom_range(0, 1));
   endtask

   task automatic load_pattern_a(input logic [15:0] pat);
      for (int k = 0; k < 256; k++) bits_a[k] = pat[15 - (k % 16)];
      idx_a = 0;
   endtask

   task automatic load_random_a();
      for (int k = 0; k < 256; k++) bits_a[k] = 1'($urandom_range(0, 1));
      idx_a = 0;
   endtask

   // Reference: word w holds dump bits 16w..16w+15, MSB-first, zeros past the end.
   task automatic model_a(input int nbits);
      logic [15:0] w;
      for (int i = 0; i < (nbits + 15) / 16; i++) begin
         w = '0;
         for (int j = 0; j < 16; j++)
            w[15 - j] = (i * 16 + j < nbits) ? bits_a[i * 16 + j] : 1'b0;
         exp_a.push_back(w);
      end
   endtask

   task automatic model_b(input int nbits);
      logic [15:0] w;
      for (int i = 0; i < (nbits + 15) / 16; i++) begin
         w = '0;
         for (int j = 0; j < 16; j++)
            w[15 - j] = (i * 16 + j < nbits) ? bits_b[i * 16 + j] : 1'b0;
         exp_b.push_back(w);
      end
   endtask

   // Pulse epoch, measure cycles to first shift and length of the shift run.
   task automatic run_dump(input bit use_b, output int lat, output int run);
      if (use_b) epoch_b = 1'b1; else epoch_a = 1'b1;
      cyc();
      epoch_a = 1'b0;
      epoch_b = 1'b0;
      lat = 1;
      while (!(use_b ? shift_b : shift_a) && lat < 10) begin
         cyc();
         lat++;
      end
      run = 0;
      while ((use_b ? shift_b : shift_a) && run < 400) begin
         cyc();
         run++;
      end
   endtask

   task automatic drain_a();
      int g = 0;
      rd_a = 1'b1;
      while (!empty_a && g < 64) begin
         cyc();
         g++;
      end
      rd_a = 1'b0;
   endtask

   task automatic compare_a(input string tag);
      check({tag, " nwords"}, 32'(got_a.size()), 32'(exp_a.size()));
      for (int i = 0; i < exp_a.size(); i++)
         if (i < got_a.size()) check($sformatf("%s w%0d", tag, i), 32'(got_a[i]), 32'(exp_a[i]));
      got_a.delete();
      exp_a.delete();
   endtask

   vec_t vecs [4];

   initial begin
      int lat, run, g, s0;

      vecs[0] = '{pat: 16'hA5A5, exp_full: 16'hA5A5, exp_last: 16'hA5A0};
      vecs[1] = '{pat: 16'hFFFF, exp_full: 16'hFFFF, exp_last: 16'hFFF0};
      vecs[2] = '{pat: 16'h1234, exp_full: 16'h1234, exp_last: 16'h1230};
      vecs[3] = '{pat: 16'h000F, exp_full: 16'h000F, exp_last: 16'h0000};

      rst_n = 1'b0;
      epoch_a = 0; sin_a = 0; rd_a = 0; clr_a = 0;
      epoch_b = 0; sin_b = 0; rd_b = 0; clr_b = 0;
      idx_a = 0; idx_b = 0; shift_cnt_a = 0; rand_rd = 0;
      for (int k = 0; k < 256; k++) begin
         bits_a[k] = 1'b0;
         bits_b[k] = 1'b0;
      end

      // Reset values.
      repeat (2) @(negedge clk);
      check("rst shift",   32'(shift_a),   32'd0);
      check("rst empty",   32'(empty_a),   32'd1);
      check("rst count",   32'(count_a),   32'd0);
      check("rst overrun", 32'(overrun_a), 32'd0);
      check("rst rdata",   32'(rdata_a),   32'd0);
      check("rst count_b", 32'(count_b),   32'd0);
      rst_n = 1'b1;
      cyc();

      // Pattern table: 108-bit dumps, six full words plus a left-justified flush word.
      for (int v = 0; v < 4; v++) begin
         load_pattern_a(vecs[v].pat);
         run_dump(1'b0, lat, run);
         check($sformatf("v%0d latency", v), 32'(lat), 32'd3);
         check($sformatf("v%0d shift run", v), 32'(run), 32'd108);
         check($sformatf("v%0d count pre-flush", v), 32'(count_a), 32'd6);
         cyc();
         check($sformatf("v%0d count post-flush", v), 32'(count_a), 32'd7);
         cyc();
         check($sformatf("v%0d overrun", v), 32'(overrun_a), 32'd0);
         for (int i = 0; i < 6; i++) exp_a.push_back(vecs[v].exp_full);
         exp_a.push_back(vecs[v].exp_last);
         drain_a();
         check($sformatf("v%0d empty after drain", v), 32'(empty_a), 32'd1);
         compare_a($sformatf("v%0d", v));
      end

      // 192-bit dump: no flush word, exactly 12 words.
      for (int k = 0; k < 256; k++) bits_b[k] = 1'($urandom_range(0, 1));
      idx_b = 0;
      model_b(192);
      run_dump(1'b1, lat, run);
      check("b latency", 32'(lat), 32'd3);
      check("b shift run", 32'(run), 32'd192);
      check("b count at end", 32'(count_b), 32'd12);
      cyc();
      cyc();
      check("b count no flush", 32'(count_b), 32'd12);
      check("b empty", 32'(empty_b), 32'd0);
      rd_b = 1'b1;
      g = 0;
      while (!empty_b && g < 64) begin
         cyc();
         g++;
      end
      rd_b = 1'b0;
      check("b nwords", 32'(got_b.size()), 32'd12);
      for (int i = 0; i < exp_b.size(); i++)
         if (i < got_b.size()) check($sformatf("b w%0d", i), 32'(got_b[i]), 32'(exp_b[i]));

      // Second epoch 50 cycles into a dump: lost, flagged, first dump intact.
      load_random_a();
      model_a(108);
      s0 = shift_cnt_a;
      epoch_a = 1'b1;
      cyc();
      epoch_a = 1'b0;
      repeat (49) cyc();
      epoch_a = 1'b1;
      cyc();
      epoch_a = 1'b0;
      g = 0;
      while (shift_a && g < 200) begin
         cyc();
         g++;
      end
      repeat (12) cyc();
      check("ovr epoch overrun", 32'(overrun_a), 32'd1);
      check("ovr shift total", 32'(shift_cnt_a - s0), 32'd108);
      check("ovr count", 32'(count_a), 32'd7);
      drain_a();
      compare_a("ovr");
      clr_a = 1'b1;
      cyc();
      clr_a = 1'b0;
      check("ovr cleared", 32'(overrun_a), 32'd0);

      // Two dumps, no reads: 8 words kept, remaining 6 dropped, then clr.
      load_random_a();
      model_a(108);
      run_dump(1'b0, lat, run);
      repeat (2) cyc();
      check("fill count 7", 32'(count_a), 32'd7);
      check("fill no overrun", 32'(overrun_a), 32'd0);
      load_random_a();
      run_dump(1'b0, lat, run);
      repeat (2) cyc();
      check("fill count 8", 32'(count_a), 32'd8);
      check("fill overrun", 32'(overrun_a), 32'd1);
      check("fill head", 32'(rdata_a), 32'(exp_a[0]));
      exp_a.delete();
      clr_a = 1'b1;
      cyc();
      clr_a = 1'b0;
      check("clr count", 32'(count_a), 32'd0);
      check("clr empty", 32'(empty_a), 32'd1);
      check("clr overrun", 32'(overrun_a), 32'd0);

      // Full FIFO with rd held high: simultaneous pop lets the push through.
      load_random_a();
      model_a(108);
      run_dump(1'b0, lat, run);
      repeat (2) cyc();
      load_random_a();
      model_a(108);
      epoch_a = 1'b1;
      cyc();
      epoch_a = 1'b0;
      g = 0;
      while (idx_a < 32 && g < 200) begin
         cyc();
         g++;
      end
      check("full before rd", 32'(count_a), 32'd8);
      rd_a = 1'b1;
      cyc();
      check("full push+pop count", 32'(count_a), 32'd8);
      g = 0;
      while (got_a.size() < 14 && g < 400) begin
         cyc();
         g++;
      end
      rd_a = 1'b0;
      cyc();
      check("full rd overrun", 32'(overrun_a), 32'd0);
      check("full rd empty", 32'(empty_a), 32'd1);
      compare_a("fullrd");

      // Reset mid-SHIFT at bit 40, then a clean dump.
      load_random_a();
      epoch_a = 1'b1;
      cyc();
      epoch_a = 1'b0;
      g = 0;
      while (idx_a < 41 && g < 200) begin
         cyc();
         g++;
      end
      check("mid count", 32'(count_a), 32'd2);
      rst_n = 1'b0;
      #1;
      check("mid rst shift", 32'(shift_a), 32'd0);
      check("mid rst count", 32'(count_a), 32'd0);
      check("mid rst empty", 32'(empty_a), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      load_random_a();
      model_a(108);
      run_dump(1'b0, lat, run);
      check("post rst run", 32'(run), 32'd108);
      repeat (2) cyc();
      drain_a();
      compare_a("postrst");

      // Random dumps with random CPU reads against the packing model.
      rand_rd = 1'b1;
      for (int n = 0; n < 4; n++) begin
         load_random_a();
         model_a(108);
         run_dump(1'b0, lat, run);
         repeat (2) cyc();
      end
      rand_rd = 1'b0;
      drain_a();
      check("rand overrun", 32'(overrun_a), 32'd0);
      compare_a("rand");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
